// File: rtl/frame_rx_if.sv
// frame_rx_if: serial-in / frame-out bundle for the Manchester frame receiver.
//   master : bit-stream source and frame consumer (drives bin, ben, dready)
//   slave  : frame_rx (drives dout, dvalid, error pulses, counters, busy)
interface frame_rx_if #(
  parameter int NBYTES = 6
);
  logic                  bin;
  logic                  ben;
  logic                  dready;
  logic [8*NBYTES-1:0]   dout;
  logic                  dvalid;
  logic                  err_manch;
  logic                  err_tail;
  logic                  err_chk;
  logic                  overrun;
  logic [7:0]            frame_cnt;
  logic [7:0]            err_cnt;
  logic                  busy;

  modport master (
    output bin, ben, dready,
    input  dout, dvalid, err_manch, err_tail, err_chk, overrun,
           frame_cnt, err_cnt, busy
  );

  modport slave (
    input  bin, ben, dready,
    output dout, dvalid, err_manch, err_tail, err_chk, overrun,
           frame_cnt, err_cnt, busy
  );
endinterface

// File: rtl/frame_rx.sv
// frame_rx: Manchester frame receiver.
// Hunts for a raw 8-bit header, Manchester-decodes NBYTES payload bytes,
// checks a raw 8-bit tail and an optional XOR checksum byte, and presents
// good frames on a valid/ready output register.
//   clk, rst : system clock, async active-high reset
//   bus      : frame_rx_if.slave
//              bin/ben     serial bit and its sample strobe
//              dout/dvalid/dready  output frame slot handshake
//              err_manch/err_tail/err_chk/overrun  1-cycle event pulses
//              frame_cnt (wrapping), err_cnt (saturating), busy
//
// state  | meaning
// S_HUNT | sliding 8-bit window searching for HEAD
// S_BODY | receiving 16*NBYTES raw payload bits, decoding pairs
// S_TAIL | receiving 8 raw tail bits, frame evaluated on the last one
module frame_rx #(
  parameter int          NBYTES = 6,
  parameter logic [7:0]  HEAD   = 8'h0F,
  parameter logic [7:0]  TAIL   = 8'hF0,
  parameter bit          CHK_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  frame_rx_if.slave bus
);

  localparam int PW = 8 * NBYTES;
  localparam int CW = $clog2(16 * NBYTES);
  localparam logic [CW-1:0] BODY_LAST = CW'(16 * NBYTES - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(7);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_BODY = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      win_q, win_d;
  logic            half_q, half_d;
  logic [PW-1:0]   dec_q, dec_d;
  logic [7:0]      tail_q, tail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            err_manch_q, err_manch_d;
  logic            err_tail_q, err_tail_d;
  logic            err_chk_q, err_chk_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [7:0]      win_shift;
  logic [7:0]      tail_shift;
  logic [7:0]      chk_acc;
  logic            chk_bad;
  logic [7:0]      err_cnt_inc;

  assign win_shift   = {win_q[6:0], bus.bin};
  assign tail_shift  = {tail_q[6:0], bus.bin};
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  // Byte 0 sits at the top of dec_q; the checksum byte is the last one in.
  always_comb begin
    chk_acc = '0;
    for (int k = 0; k < NBYTES - 1; k++) begin
      chk_acc = chk_acc ^ dec_q[PW-1-8*k -: 8];
    end
  end

  assign chk_bad = CHK_EN && (chk_acc != dec_q[7:0]);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    half_d      = half_q;
    dec_d       = dec_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    dvalid_d    = dvalid_q;
    err_manch_d = 1'b0;
    err_tail_d  = 1'b0;
    err_chk_d   = 1'b0;
    overrun_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    // Consumer handshake runs every clk; a frame load below overrides it.
    if (dvalid_q && bus.dready) dvalid_d = 1'b0;

    if (bus.ben) begin
      unique case (state_q)
        S_HUNT: begin
          win_d = win_shift;
          if (win_shift == HEAD) begin
            state_d = S_BODY;
            cnt_d   = BODY_LAST;
            win_d   = '0;
          end
        end

        S_BODY: begin
          cnt_d = cnt_q - CW'(1);
          // Down-count from an odd value: odd = first bit of a pair.
          if (cnt_q[0]) begin
            half_d = bus.bin;
          end else if (half_q == bus.bin) begin
            err_manch_d = 1'b1;
            err_cnt_d   = err_cnt_inc;
            state_d     = S_HUNT;
            win_d       = '0;
          end else begin
            // 10 -> 1, 01 -> 0: the decoded bit equals the earlier half.
            dec_d = {dec_q[PW-2:0], half_q};
            if (cnt_q == '0) begin
              state_d = S_TAIL;
              cnt_d   = TAIL_LAST;
            end
          end
        end

        S_TAIL: begin
          tail_d = tail_shift;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_HUNT;
            win_d   = '0;
            if (tail_shift != TAIL) begin
              err_tail_d = 1'b1;
              err_cnt_d  = err_cnt_inc;
            end else if (chk_bad) begin
              err_chk_d = 1'b1;
              err_cnt_d = err_cnt_inc;
            end else if (!dvalid_q || bus.dready) begin
              dout_d      = dec_q;
              dvalid_d    = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_HUNT;
          win_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HUNT;
      win_q       <= '0;
      half_q      <= 1'b0;
      dec_q       <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      err_manch_q <= 1'b0;
      err_tail_q  <= 1'b0;
      err_chk_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      half_q      <= half_d;
      dec_q       <= dec_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      err_manch_q <= err_manch_d;
      err_tail_q  <= err_tail_d;
      err_chk_q   <= err_chk_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.err_manch = err_manch_q;
  assign bus.err_tail  = err_tail_q;
  assign bus.err_chk   = err_chk_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = (state_q != S_HUNT);

endmodule

// File: doc/frame_rx.md
# frame_rx

Parametrised Manchester frame receiver for the optical RX path. It consumes the recovered serial bit stream (`bin`, qualified by the `ben` strobe) and hunts for a raw 8-bit header. It then Manchester-decodes `NBYTES` payload bytes, checks the raw tail and an optional XOR checksum, and presents each good frame on a valid/ready output register. It replaces fixed-width sliding-window decoding with an explicit state machine, error reporting and status counters.

## Interface
- `NBYTES`, 6, decoded payload bytes per frame including checksum byte (2..16)
- `HEAD`, 8'h0F, raw (not Manchester) header pattern
- `TAIL`, 8'hF0, raw tail pattern
- `CHK_EN`, 1, 1 = last payload byte is XOR of bytes 0..NBYTES-2; 0 = no check

- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `bin` in 1: serial data bit
- `ben` in 1: bit strobe; `bin` sampled only on cycles with `ben`=1
- `dout` out 8*NBYTES: frame payload; byte 0 (first received) in `dout[8*NBYTES-1 -: 8]`
- `dvalid` out 1: `dout` holds an unconsumed good frame
- `dready` in 1: consumer accepts `dout` when `dvalid`&&`dready`
- `err_manch` out 1: 1-cycle pulse, illegal Manchester pair
- `err_tail` out 1: 1-cycle pulse, tail mismatch
- `err_chk` out 1: 1-cycle pulse, checksum mismatch
- `overrun` out 1: 1-cycle pulse, good frame dropped because the output slot was full
- `frame_cnt` out 8: good frames delivered into the output slot, wraps 255->0
- `err_cnt` out 8: bad frames (manch/tail/chk), saturates at 255
- `busy` out 1: state != HUNT

## Operation
- All state advances only on `ben`=1 cycles; `ben`=0 freezes the FSM, counters and shift registers.
- The first received bit is the MSB. Manchester pair {earlier, later}: 10 -> 1, 01 -> 0; 00 and 11 are illegal.
- States:
  - HUNT: shift `bin` into the 8-bit window. When {window[6:0],bin}==HEAD, go to BODY with bit counter 0.
  - BODY: shift into the payload buffer and check each completed pair. On an illegal pair, pulse `err_manch`, increment `err_cnt` and abort to HUNT. After 16*NBYTES bits, go to TAIL.
  - TAIL: collect 8 bits. On the 8th bit, evaluate the frame and return to HUNT.
- On every entry to HUNT the window is cleared to 0, so a full header must be re-received; header bits never overlap a previous frame.
- Evaluation priority:
  1. tail != TAIL -> `err_tail`
  2. else CHK_EN and checksum mismatch -> `err_chk`
  3. else the frame is good.
- Only one error pulse is raised per frame.
- Good frame:
  - If the slot is free, or `dready`=1 on the same cycle (consumer frees it), load `dout`, set `dvalid` and increment `frame_cnt`.
  - Otherwise pulse `overrun`, drop the frame and keep the old `dout`. Overrun does not touch `err_cnt` or `frame_cnt`.
- `dvalid` clears on `dvalid`&&`dready` unless a new frame loads that cycle. `dout` stays stable while `dvalid`=1.

## Timing
- Reset (async, any time including mid-frame): state HUNT, window/buffer 0, `dout`=0, `dvalid`=0, all pulses 0, `frame_cnt`=0, `err_cnt`=0, `busy`=0.
- Frame length is 16+16*NBYTES raw bits (112 for NBYTES=6).
- The header match registers on the `ben` edge of the 8th header bit, and `busy`=1 from the next cycle.
- `dvalid`, `frame_cnt`, error pulses and `overrun` update on the clock edge of the last tail bit's `ben` cycle, i.e. visible 1 cycle later.
- `err_manch` fires on the edge of the offending pair's second bit, and `busy` drops on the same edge.
- Pulses are exactly 1 clk wide regardless of `ben` spacing.
- `dready` is sampled every clk, independent of `ben`.

## Test plan
- Back-to-back frames with `ben` every 3rd clk, NBYTES=6, header 0x0F, payload 12 34 56 78 9A 92, tail 0xF0 -> `dvalid`=1, `dout`=48'h123456789A92, `frame_cnt`=1; hold `dready`=0, then a 2nd identical frame -> `overrun` pulse, `frame_cnt` stays 1.
- Same frame with checksum byte 0x93 -> `err_chk` pulse, `err_cnt`=1, `dvalid` stays 0. Repeat with CHK_EN=0 -> accepted.
- Raw pair 11 inserted in payload byte 2 -> `err_manch` pulse on that pair, `busy`=0 next cycle. An immediately following valid frame is received correctly.
- Tail 0xF1 -> `err_tail` only (no `err_chk`), `err_cnt`=1. Drive 300 bad frames -> `err_cnt` saturates at 255.
- Assert `rst` for 1 clk at bit 50 of a frame, then resume sending -> all outputs 0, and the remaining bits do not produce a frame. A following complete frame is accepted.
- `dready` tied high with a good frame completing -> `dvalid` asserts for 1 cycle. Simultaneous `dready` and a new frame load -> `dvalid` stays 1 with the new `dout`, and no `overrun`.
